// File: rtl/conv1d_tile_sequencer_pkg.sv
// Shared definitions for the 1-D convolution tile sequencer.
//   - Engine opcode constants understood by the conv engine.
//   - Geometry constants (kernel length, tile length, halo width in words).
//   - Sequencer state enum.
//   - relu_bytes(): per-byte clamp used when CONV_SEQ_RELU_EN is defined.
package conv_pkg;

  localparam logic [6:0] OP_INIT     = 7'd0;
  localparam logic [6:0] OP_WR_IN    = 7'd1;
  localparam logic [6:0] OP_WR_KER   = 7'd2;
  localparam logic [6:0] OP_RD_OUT   = 7'd3;
  localparam logic [6:0] OP_RD_SIZE  = 7'd4;
  localparam logic [6:0] OP_START    = 7'd5;
  localparam logic [6:0] OP_SET_BIAS = 7'd8;
  localparam logic [6:0] OP_NOP      = 7'd9;

  localparam int KERNEL_LEN = 8;
  localparam int TILE_LEN   = 8;
  localparam int HALO_WORDS = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_KERN,
    S_BIAS,
    S_FETCH,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  // Any byte whose sign bit is set becomes zero; others pass unchanged.
  function automatic logic [31:0] relu_bytes(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) begin
      if (w[i*8+7]) r[i*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv1d_tile_sequencer_if.sv
// Memory and engine bus of the tile sequencer.
//   master : the sequencer (drives SRAM strobes/addresses and engine commands)
//   slave  : SRAMs + conv engine
// Signals: mem_rd_en/mem_rd_addr/mem_rd_data (input SRAM, 1-cycle latency),
//          out_wr_en/out_wr_addr/out_wr_data (output SRAM),
//          eng_cmd/eng_inp0/eng_inp1 (engine command), eng_ret/eng_valid.
interface conv1d_tile_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;
  logic [31:0]       out_wr_data;
  logic [6:0]        eng_cmd;
  logic [31:0]       eng_inp0;
  logic [31:0]       eng_inp1;
  logic [31:0]       eng_ret;
  logic              eng_valid;

  modport master (
    output mem_rd_en, mem_rd_addr, input mem_rd_data,
    output out_wr_en, out_wr_addr, out_wr_data,
    output eng_cmd, eng_inp0, eng_inp1,
    input  eng_ret, eng_valid
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, output mem_rd_data,
    input  out_wr_en, out_wr_addr, out_wr_data,
    input  eng_cmd, eng_inp0, eng_inp1,
    output eng_ret, eng_valid
  );
endinterface

// File: rtl/conv1d_tile_sequencer_window_addr.sv
// conv_seq_window_addr: combinational halo-window address generator.
// Tile t covers window words w = 2t-1 .. 2t+2 relative to in_base.
//   tile      : tile index
//   word_idx  : word within the window (0..3)
//   len_words : job length in words
//   in_base   : input SRAM base address
//   addr      : in_base + w, wrapping modulo 2^ADDR_W
//   pad       : word lies outside the vector (w < 0 or w >= len_words)
module conv_seq_window_addr #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic [LEN_W-2:0]  tile,
  input  logic [1:0]        word_idx,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [ADDR_W-1:0] in_base,
  output logic [ADDR_W-1:0] addr,
  output logic              pad
);
  // Work with w+1 so the arithmetic stays unsigned: w < 0 becomes w+1 == 0.
  logic [LEN_W+1:0] w_plus1;
  logic [LEN_W+1:0] w_idx;

  assign w_plus1 = {2'b00, tile, 1'b0} + {{LEN_W{1'b0}}, word_idx};
  assign w_idx   = w_plus1 - {{(LEN_W+1){1'b0}}, 1'b1};
  assign pad     = (w_plus1 == '0) || (w_plus1 > {2'b00, len_words});
  assign addr    = in_base + ADDR_W'(w_idx);
endmodule

// File: rtl/conv1d_tile_sequencer.sv
// conv1d_tile_sequencer: drives the 8-output int8 conv engine across an
// arbitrarily long input vector, one 8-sample tile at a time.
// Ports:
//   clk, reset (synchronous, active-high)
//   start, len_words, in_base, out_base, kernel0, kernel1, bias : job request
//   busy, done, err                                              : job status
//   bus (conv1d_tile_sequencer_if.master) : input SRAM, output SRAM, engine
// Optional build macro: CONV_SEQ_RELU_EN clamps negative result bytes to 0.
module conv1d_tile_sequencer
  import conv_pkg::*;
#(
  parameter int         ADDR_W  = 10,
  parameter int         LEN_W   = 10,
  parameter logic [6:0] ENG_NOP = 7'd9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [31:0]       kernel0,
  input  logic [31:0]       kernel1,
  input  logic [7:0]        bias,
  output logic              busy,
  output logic              done,
  output logic              err,
  conv1d_tile_sequencer_if.master bus
);

  seq_state_t        state, state_n;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] in_base_q, out_base_q;
  logic [31:0]       ker0_q, ker1_q;
  logic [7:0]        bias_q;
  logic              err_q;
  logic [LEN_W-2:0]  tile;
  logic [2:0]        phase;
  logic              seen_low, pad_q, rd_q, rd_idx_q;
  logic [ADDR_W-1:0] win_addr;
  logic              win_pad, bad_len, last_tile;
  logic [1:0]        wr_idx;
  logic              out_wr_en_q;
  logic [ADDR_W-1:0] out_wr_addr_q;
  logic [31:0]       out_wr_data_q;

  assign bad_len   = (len_words == '0) || len_words[0];
  assign last_tile = (tile == (len_q[LEN_W-1:1] - {{(LEN_W-2){1'b0}}, 1'b1}));
  assign wr_idx    = phase[1:0] - 2'd1;

  conv_seq_window_addr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_win (
    .tile(tile), .word_idx(phase[1:0]), .len_words(len_q),
    .in_base(in_base_q), .addr(win_addr), .pad(win_pad)
  );

  // Next-state and engine/SRAM-read outputs. FETCH phase k reads word k
  // while writing word k-1 to the engine; the pad flag of the previous
  // phase selects a zero word instead of SRAM data.
  always_comb begin
    state_n          = state;
    bus.eng_cmd      = ENG_NOP;
    bus.eng_inp0     = '0;
    bus.eng_inp1     = '0;
    bus.mem_rd_en    = 1'b0;
    bus.mem_rd_addr  = '0;
    case (state)
      S_IDLE:  if (start) state_n = bad_len ? S_DONE : S_SYNC;
      S_SYNC:  if (bus.eng_valid) state_n = S_KERN;
      S_KERN: begin
        bus.eng_cmd  = OP_WR_KER;
        bus.eng_inp0 = {31'b0, phase[0]};
        bus.eng_inp1 = phase[0] ? ker1_q : ker0_q;
        if (phase[0]) state_n = S_BIAS;
      end
      S_BIAS: begin
        bus.eng_cmd  = OP_SET_BIAS;
        bus.eng_inp0 = {{24{bias_q[7]}}, bias_q};
        state_n      = S_FETCH;
      end
      S_FETCH: begin
        if (phase != 3'd4 && !win_pad) begin
          bus.mem_rd_en   = 1'b1;
          bus.mem_rd_addr = win_addr;
        end
        if (phase != 3'd0) begin
          bus.eng_cmd  = OP_WR_IN;
          bus.eng_inp0 = {30'b0, wr_idx};
          bus.eng_inp1 = pad_q ? 32'h0 : bus.mem_rd_data;
        end
        if (phase == 3'd4) state_n = S_START;
      end
      S_START: begin
        bus.eng_cmd = OP_START;
        state_n     = S_WAIT;
      end
      // The engine must visibly drop eng_valid before its result counts.
      S_WAIT:  if (bus.eng_valid && seen_low) state_n = S_DRAIN;
      S_DRAIN: begin
        if (phase != 3'd2) begin
          bus.eng_cmd  = OP_RD_OUT;
          bus.eng_inp0 = {31'b0, phase[0]};
        end else begin
          state_n = last_tile ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register, job latches, phase/tile counters and the output-SRAM
  // write pipeline (eng_ret is registered into the write port the cycle it
  // is valid, so the third DRAIN phase covers the second word's write).
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      len_q         <= '0;
      in_base_q     <= '0;
      out_base_q    <= '0;
      ker0_q        <= '0;
      ker1_q        <= '0;
      bias_q        <= '0;
      err_q         <= 1'b0;
      tile          <= '0;
      phase         <= '0;
      seen_low      <= 1'b0;
      pad_q         <= 1'b0;
      rd_q          <= 1'b0;
      rd_idx_q      <= 1'b0;
      out_wr_en_q   <= 1'b0;
      out_wr_addr_q <= '0;
      out_wr_data_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        len_q      <= len_words;
        in_base_q  <= in_base;
        out_base_q <= out_base;
        ker0_q     <= kernel0;
        ker1_q     <= kernel1;
        bias_q     <= bias;
        err_q      <= bad_len;
        tile       <= '0;
      end
      if (state_n != state) phase <= '0;
      else if (state inside {S_KERN, S_FETCH, S_DRAIN}) phase <= phase + 3'd1;
      if (state == S_START) seen_low <= 1'b0;
      else if (state == S_WAIT && !bus.eng_valid) seen_low <= 1'b1;
      if (state == S_DRAIN && state_n == S_FETCH) tile <= tile + 1'b1;
      pad_q       <= win_pad;
      rd_q        <= (state == S_DRAIN) && (phase != 3'd2);
      rd_idx_q    <= phase[0];
      out_wr_en_q <= rd_q;
      if (rd_q) begin
        out_wr_addr_q <= out_base_q + ADDR_W'({tile, 1'b0}) + ADDR_W'(rd_idx_q);
`ifdef CONV_SEQ_RELU_EN
        out_wr_data_q <= relu_bytes(bus.eng_ret);
`else
        out_wr_data_q <= bus.eng_ret;
`endif
      end
    end
  end

  assign bus.out_wr_en   = out_wr_en_q;
  assign bus.out_wr_addr = out_wr_addr_q;
  assign bus.out_wr_data = out_wr_data_q;
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign err             = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_conv1d_tile_sequencer.sv
// Self-checking bench for conv1d_tile_sequencer with SRAM and engine models.
module tb_conv1d_tile_sequencer;

  localparam int ENG_LAT = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  len_words = '0, in_base = '0, out_base = '0;
  logic [31:0] kernel0 = '0, kernel1 = '0;
  logic [7:0]  bias = '0;
  logic        busy, done, err;

  conv1d_tile_sequencer_if #(.ADDR_W(10)) bus();

  conv1d_tile_sequencer #(.ADDR_W(10), .LEN_W(10), .ENG_NOP(7'd9)) dut (
    .clk(clk), .reset(reset), .start(start), .len_words(len_words),
    .in_base(in_base), .out_base(out_base), .kernel0(kernel0),
    .kernel1(kernel1), .bias(bias), .busy(busy), .done(done), .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int npass = 0, ntotal = 0, cyc = 0;
  logic [31:0] in_mem [1024];
  logic [31:0] out_mem [1024];

  // Job context used by the golden model and the compare process
  int          g_len = 0;
  logic [9:0]  g_base = '0, g_obase = '0;
  logic [31:0] g_k0 = '0, g_k1 = '0;
  logic [7:0]  g_bias = '0;
  logic        g_quiet = 1'b0;
  logic [31:0] exp_words [1024];
  int          wr_count = 0, rd_count = 0, start_cyc = 0;
  int          lat_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    ntotal++;
    if (act === expv) npass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  // Input/output SRAM models (1-cycle read latency)
  always @(posedge clk) begin
    cyc++;
    if (bus.mem_rd_en) bus.mem_rd_data <= in_mem[bus.mem_rd_addr];
    if (bus.out_wr_en) out_mem[bus.out_wr_addr] <= bus.out_wr_data;
  end

  // Engine model: 4 input words, 8 taps, bias; no reset
  logic [31:0] e_in [4];
  logic [31:0] e_ker [2];
  logic [7:0]  e_bias = '0;
  logic [31:0] e_out [2];
  int          e_cnt = 0;

  function automatic logic [31:0] engWord(input int i);
    logic [31:0] r;
    int acc, n;
    byte xb, kb;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      kb = e_bias;
      acc = int'(kb);
      for (int k = 0; k < 8; k++) begin
        n = 4 * i + b + k;
        xb = e_in[n / 4][(3 - n % 4) * 8 +: 8];
        kb = e_ker[k / 4][(3 - k % 4) * 8 +: 8];
        acc = acc + int'(xb) * int'(kb);
      end
      r[(3 - b) * 8 +: 8] = acc[7:0];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (e_cnt > 0) e_cnt <= e_cnt - 1;
    case (bus.eng_cmd)
      7'd1: e_in[bus.eng_inp0[1:0]] <= bus.eng_inp1;
      7'd2: e_ker[bus.eng_inp0[0]] <= bus.eng_inp1;
      7'd8: e_bias <= bus.eng_inp0[7:0];
      7'd5: begin
        e_out[0] <= engWord(0);
        e_out[1] <= engWord(1);
        e_cnt    <= ENG_LAT;
      end
      7'd3: bus.eng_ret <= e_out[bus.eng_inp0[0]];
      default: ;
    endcase
  end
  assign bus.eng_valid = (e_cnt == 0);

  // Golden model over the whole vector: output word o, byte b is
  // bias + sum_k x[4o+b-4+k]*tap[k], samples beyond either end are zero.
  function automatic int sampleAt(input int n);
    logic [31:0] w;
    byte sb;
    if (n < 0 || n >= 4 * g_len) return 0;
    w = in_mem[10'(int'(g_base) + n / 4)];
    sb = w[(3 - n % 4) * 8 +: 8];
    return int'(sb);
  endfunction

  function automatic logic [31:0] goldenWord(input int o);
    logic [31:0] r, kw;
    logic [7:0] v;
    byte kb;
    int acc;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      kb = g_bias;
      acc = int'(kb);
      for (int k = 0; k < 8; k++) begin
        kw = (k < 4) ? g_k0 : g_k1;
        kb = kw[(3 - k % 4) * 8 +: 8];
        acc = acc + sampleAt(4 * o + b - 4 + k) * int'(kb);
      end
      v = acc[7:0];
`ifdef CONV_SEQ_RELU_EN
      if (v[7]) v = 8'h00;
`endif
      r[(3 - b) * 8 +: 8] = v;
    end
    return r;
  endfunction

  // Compare process: checks bus activity against the job model every cycle
  always @(negedge clk) begin
    logic [9:0] off;
    if (!reset) begin
      if (bus.eng_cmd != 7'd9) checkOutput("cmd_while_engine_busy", {31'b0, bus.eng_valid}, 32'd1);
      if (bus.eng_cmd == 7'd5) start_cyc = cyc;
      if (g_quiet) begin
        checkOutput("badlen_cmd", {25'b0, bus.eng_cmd}, 32'd9);
        checkOutput("badlen_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
        checkOutput("badlen_wr_en", {31'b0, bus.out_wr_en}, 32'd0);
      end
      if (bus.mem_rd_en) begin
        rd_count++;
        off = bus.mem_rd_addr - g_base;
        checkOutput("rd_in_range", {31'b0, int'(off) < g_len}, 32'd1);
      end
      if (bus.out_wr_en) begin
        wr_count++;
        off = bus.out_wr_addr - g_obase;
        checkOutput("wr_in_range", {31'b0, int'(off) < g_len}, 32'd1);
        if (int'(off) < g_len)
          checkOutput($sformatf("wr_data[%0d]", off), bus.out_wr_data, exp_words[off]);
        if (off[0]) lat_q.push_back(cyc - start_cyc);
      end
    end
  end

  // Drives a job request for one cycle (called at a negedge)
  task automatic applyStimulus(input int len, input logic [9:0] ib, input logic [9:0] ob,
                               input logic [31:0] k0, input logic [31:0] k1, input logic [7:0] bs);
    g_len = len; g_base = ib; g_obase = ob; g_k0 = k0; g_k1 = k1; g_bias = bs;
    for (int o = 0; o < len; o++) exp_words[o] = goldenWord(o);
    wr_count = 0; rd_count = 0; lat_q.delete();
    len_words = 10'(len); in_base = ib; out_base = ob;
    kernel0 = k0; kernel1 = k1; bias = bs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input logic exp_err);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    checkOutput({name, "_done_seen"}, {31'b0, done}, 32'd1);
    checkOutput({name, "_err"}, {31'b0, err}, {31'b0, exp_err});
    @(negedge clk);
    checkOutput({name, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      in_mem[i] = '0;
      out_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
    checkOutput("rst_wr_en", {31'b0, bus.out_wr_en}, 32'd0);
    checkOutput("rst_cmd", {25'b0, bus.eng_cmd}, 32'd9);
    checkOutput("rst_inp0", bus.eng_inp0, 32'd0);
    checkOutput("rst_inp1", bus.eng_inp1, 32'd0);
    checkOutput("rst_wr_addr", {22'b0, bus.out_wr_addr}, 32'd0);
    checkOutput("rst_wr_data", bus.out_wr_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single tile
    in_mem[100] = 32'h07060504; in_mem[101] = 32'h03020100;
    applyStimulus(2, 10'd100, 10'd200, 32'h02020202, 32'h02020202, 8'd1);
    checkOutput("t1_busy", {31'b0, busy}, 32'd1);
    waitDone("t1", 1'b0);
    checkOutput("t1_out0", out_mem[200], 32'h2D333739);
    checkOutput("t1_out1", out_mem[201], 32'h392B1F15);
    checkOutput("t1_writes", wr_count, 32'd2);

    // Two tiles, wrapping addresses, extra start while busy
    for (int w = 0; w < 4; w++)
      in_mem[10'(1022 + w)] = {8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)};
    applyStimulus(4, 10'd1022, 10'd1021, 32'h01010101, 32'h01010101, 8'd0);
    repeat (6) @(negedge clk);
    len_words = 10'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; len_words = 10'd4;
    checkOutput("t2_extra_start_ignored", {31'b0, done}, 32'd0);
    waitDone("t2", 1'b0);
    checkOutput("t2_out0", out_mem[1021], 32'h0A0F151C);
    checkOutput("t2_out3", out_mem[0], 32'h645B5146);
    checkOutput("t2_writes", wr_count, 32'd4);
    checkOutput("t2_tiles", lat_q.size(), 32'd2);
    if (lat_q.size() == 2) checkOutput("t2_lat_equal", lat_q[1], lat_q[0]);

    // Illegal lengths
    g_quiet = 1'b1;
    applyStimulus(3, 10'd5, 10'd6, 32'h0, 32'h0, 8'd0);
    checkOutput("t3_done", {31'b0, done}, 32'd1);
    checkOutput("t3_err", {31'b0, err}, 32'd1);
    @(negedge clk);
    checkOutput("t3_busy_after", {31'b0, busy}, 32'd0);
    applyStimulus(0, 10'd5, 10'd6, 32'h0, 32'h0, 8'd0);
    checkOutput("t3b_err", {31'b0, err}, 32'd1);
    @(negedge clk);
    g_quiet = 1'b0;

    // Reset while waiting on the engine, then a fresh job
    applyStimulus(2, 10'd100, 10'd300, 32'h02020202, 32'h02020202, 8'd1);
    for (int i = 0; i < 500 && bus.eng_cmd != 7'd5; i++) @(negedge clk);
    checkOutput("t4_reached_start", {25'b0, bus.eng_cmd}, 32'd5);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t4_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("t4_rst_cmd", {25'b0, bus.eng_cmd}, 32'd9);
    reset = 1'b0;
    applyStimulus(2, 10'd100, 10'd310, 32'h02020202, 32'h02020202, 8'd1);
    checkOutput("t4_sync_nop", {25'b0, bus.eng_cmd}, 32'd9);
    waitDone("t4", 1'b0);
    checkOutput("t4_out0", out_mem[310], 32'h2D333739);
    checkOutput("t4_out1", out_mem[311], 32'h392B1F15);

    // Edge padding with truncation
    in_mem[50] = 32'h7F7F7F7F; in_mem[51] = 32'h7F7F7F7F;
    applyStimulus(2, 10'd50, 10'd60, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'd0);
    waitDone("t5", 1'b0);
    checkOutput("t5_out0", out_mem[60], 32'h04050607);
    checkOutput("t5_out1", out_mem[61], 32'h08070605);
    checkOutput("t5_reads", rd_count, 32'd2);

    // Negative results (clamped when the ReLU option is built in)
    applyStimulus(2, 10'd100, 10'd400, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd0);
    waitDone("t6", 1'b0);
`ifdef CONV_SEQ_RELU_EN
    checkOutput("t6_out0", out_mem[400], 32'h00000000);
    checkOutput("t6_out1", out_mem[401], 32'h00000000);
`else
    checkOutput("t6_out0", out_mem[400], 32'hEAE7E5E4);
    checkOutput("t6_out1", out_mem[401], 32'hE4EBF1F6);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
